// File: rtl/flit_sink.sv
// flit_sink: receive-side endpoint for the router flit interface.
//
// Parses HEAD/DATA/TAIL framing of incoming flits, measures packet length,
// accumulates payload bit toggles between consecutive flits of a packet,
// reports per-packet results and records the first framing error.
//
// Optional feature (compile-time macro FLIT_SINK_VCH_CHECK_EN):
//   when defined, a DATA/TAIL flit in a packet body whose ivch differs from
//   the VC latched at HEAD raises error code 4 (the flit is still accepted).
//
// Handshake: valid-only stream, no ready. A flit is consumed on every rising
// clk edge where ivalid=1; ivalid=0 cycles are bubbles and change nothing.
//
// Ports:
//   clk          system clock, rising edge
//   rst_         asynchronous active-low reset
//   idata        incoming flit: type in [DATAW-1:DATAW-2], payload below
//   ivalid       flit valid
//   ivch         virtual channel of the flit
//   pkt_done     one-cycle pulse, cycle after a TAIL completes a packet
//   pkt_len      flit count of last packet (HEAD..TAIL), saturating
//   pkt_vch      VC latched from HEAD of last packet
//   pkt_toggles  payload bit toggles of last packet, saturating
//   pkt_cnt      completed packet counter, wraps
//   err          sticky error flag
//   err_code     first error: 1 orphan, 2 nested head, 3 bad type, 4 vch
//   state_dbg    FSM state (0 IDLE, 1 BODY)
module flit_sink #(
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int LENW  = 8,
    parameter int TOGW  = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    output logic             pkt_done,
    output logic [LENW-1:0]  pkt_len,
    output logic [VCHW-1:0]  pkt_vch,
    output logic [TOGW-1:0]  pkt_toggles,
    output logic [CNTW-1:0]  pkt_cnt,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             state_dbg
);

    localparam int PW  = DATAW - 2;
    localparam int PCW = $clog2(PW + 1);

    localparam logic [1:0] TY_NONE = 2'b00;
    localparam logic [1:0] TY_HEAD = 2'b01;
    localparam logic [1:0] TY_TAIL = 2'b10;
    localparam logic [1:0] TY_DATA = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   prev_q;
    logic [VCHW-1:0] vch_q;
    logic [LENW-1:0] len_q;
    logic [TOGW-1:0] tog_q;

    logic [1:0]      ftype;
    logic [PW-1:0]   payload;
    logic [PW-1:0]   diff;
    logic [PCW-1:0]  pop;
    logic [LENW-1:0] len_inc;
    logic [TOGW:0]   tog_wide;
    logic [TOGW-1:0] tog_sum;

    logic            start_pkt;
    logic            accum;
    logic            finish;
    logic            err_hit;
    logic [2:0]      err_val;

    assign ftype     = idata[DATAW-1 -: 2];
    assign payload   = idata[PW-1:0];
    assign diff      = payload ^ prev_q;
    assign state_dbg = (state_q == S_BODY);

    always_comb begin
        pop = '0;
        for (int i = 0; i < PW; i++) begin
            pop = pop + PCW'(diff[i]);
        end
    end

    // Saturating length and toggle updates for the flit being accumulated.
    assign len_inc  = (len_q == '1) ? len_q : len_q + LENW'(1);
    assign tog_wide = {1'b0, tog_q} + (TOGW+1)'(pop);
    assign tog_sum  = tog_wide[TOGW] ? '1 : tog_wide[TOGW-1:0];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_pkt = 1'b0;
        accum     = 1'b0;
        finish    = 1'b0;
        err_hit   = 1'b0;
        err_val   = 3'd0;
        if (ivalid) begin
            case (ftype)
                TY_NONE: begin
                    err_hit = 1'b1;
                    err_val = 3'd3;
                end
                TY_HEAD: begin
                    // A HEAD inside a body drops the open packet and restarts.
                    if (state_q == S_BODY) begin
                        err_hit = 1'b1;
                        err_val = 3'd2;
                    end
                    start_pkt = 1'b1;
                    state_d   = S_BODY;
                end
                TY_DATA, TY_TAIL: begin
                    if (state_q == S_IDLE) begin
                        err_hit = 1'b1;
                        err_val = 3'd1;
                    end else begin
                        accum = 1'b1;
`ifdef FLIT_SINK_VCH_CHECK_EN
                        if (ivch != vch_q) begin
                            err_hit = 1'b1;
                            err_val = 3'd4;
                        end
`endif
                        if (ftype == TY_TAIL) begin
                            finish  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_q      <= '0;
            vch_q       <= '0;
            len_q       <= '0;
            tog_q       <= '0;
            pkt_done    <= 1'b0;
            pkt_len     <= '0;
            pkt_vch     <= '0;
            pkt_toggles <= '0;
            pkt_cnt     <= '0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            if (start_pkt) begin
                vch_q  <= ivch;
                prev_q <= payload;
                len_q  <= LENW'(1);
                tog_q  <= '0;
            end else if (accum) begin
                prev_q <= payload;
                len_q  <= len_inc;
                tog_q  <= tog_sum;
            end

            pkt_done <= finish;
            if (finish) begin
                pkt_len     <= len_inc;
                pkt_vch     <= vch_q;
                pkt_toggles <= tog_sum;
                pkt_cnt     <= pkt_cnt + CNTW'(1);
            end

            // Only the first error since reset is recorded.
            if (err_hit && !err) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
        end
    end

endmodule

// File: tb/tb_flit_sink.sv
// Testbench for flit_sink: directed framing scenarios plus randomized
// streams, checked every cycle against a packet-level reference model.
module tb_flit_sink;

    localparam int DATAW = 66;
    localparam int VCHW  = 2;
    localparam int LENW  = 8;
    localparam int TOGW  = 16;
    localparam int CNTW  = 16;
    localparam int W     = LENW + VCHW + TOGW;

    localparam logic [1:0] TY_NONE = 2'b00;
    localparam logic [1:0] TY_HEAD = 2'b01;
    localparam logic [1:0] TY_TAIL = 2'b10;
    localparam logic [1:0] TY_DATA = 2'b11;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic [DATAW-1:0] idata = '0;
    logic             ivalid = 1'b0;
    logic [VCHW-1:0]  ivch = '0;
    logic             pkt_done;
    logic [LENW-1:0]  pkt_len;
    logic [VCHW-1:0]  pkt_vch;
    logic [TOGW-1:0]  pkt_toggles;
    logic [CNTW-1:0]  pkt_cnt;
    logic             err;
    logic [2:0]       err_code;
    logic             state_dbg;

    always #5 clk = ~clk;

    flit_sink #(
        .DATAW(DATAW), .VCHW(VCHW), .LENW(LENW), .TOGW(TOGW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_vch(pkt_vch),
        .pkt_toggles(pkt_toggles), .pkt_cnt(pkt_cnt), .err(err),
        .err_code(err_code), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit              m_in_pkt;
    logic [VCHW-1:0] m_vch;
    logic [63:0]     m_pays[$];
    bit              e_done;
    logic [LENW-1:0] e_len;
    logic [VCHW-1:0] e_vch;
    logic [TOGW-1:0] e_tog;
    logic [CNTW-1:0] e_cnt;
    bit              e_err;
    logic [2:0]      e_code;

    function automatic void model_reset();
        m_in_pkt = 0; m_vch = '0; m_pays.delete();
        e_done = 0; e_len = '0; e_vch = '0; e_tog = '0; e_cnt = '0;
        e_err = 0; e_code = 3'd0;
        exp_q.delete();
    endfunction

    function automatic void note_err(input int code);
        if (!e_err) begin
            e_err  = 1;
            e_code = 3'(code);
        end
    endfunction

    function automatic void model_complete();
        longint len = m_pays.size();
        longint tog = 0;
        for (int i = 1; i < m_pays.size(); i++) tog += $countones(m_pays[i] ^ m_pays[i-1]);
        if (len > 255) len = 255;
        if (tog > 65535) tog = 65535;
        e_done = 1;
        e_len  = LENW'(len);
        e_vch  = m_vch;
        e_tog  = TOGW'(tog);
        e_cnt  = e_cnt + 1'b1;
        exp_q.push_back({e_len, e_vch, e_tog});
        m_in_pkt = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [1:0] ty,
                                       input logic [63:0] pay, input logic [VCHW-1:0] vc);
        e_done = 0;
        if (!v) return;
        if (ty == TY_NONE) begin
            note_err(3);
        end else if (ty == TY_HEAD) begin
            if (m_in_pkt) note_err(2);
            m_pays.delete();
            m_pays.push_back(pay);
            m_vch    = vc;
            m_in_pkt = 1;
        end else if (!m_in_pkt) begin
            note_err(1);
        end else begin
`ifdef FLIT_SINK_VCH_CHECK_EN
            if (vc != m_vch) note_err(4);
`endif
            m_pays.push_back(pay);
            if (ty == TY_TAIL) model_complete();
        end
    endfunction

    task automatic check_outputs();
        logic [W-1:0] r;
        check_eq("pkt_done", pkt_done, e_done);
        check_eq("pkt_len", pkt_len, e_len);
        check_eq("pkt_vch", pkt_vch, e_vch);
        check_eq("pkt_toggles", pkt_toggles, e_tog);
        check_eq("pkt_cnt", pkt_cnt, e_cnt);
        check_eq("err", err, e_err);
        check_eq("err_code", err_code, e_code);
        check_eq("state_dbg", state_dbg, m_in_pkt);
        if (pkt_done === 1'b1 && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check_eq("result_q", {pkt_len, pkt_vch, pkt_toggles}, r);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic [1:0] ty, input logic [63:0] pay,
                        input logic [VCHW-1:0] vc);
        ivalid = v;
        idata  = {ty, pay};
        ivch   = vc;
        @(posedge clk);
        model_step(v, ty, pay, vc);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic bubbles(input int n);
        repeat (n) step(1'b0, 2'($urandom_range(0, 3)), rnd64(), 2'($urandom_range(0, 3)));
    endtask

    task automatic do_reset();
        ivalid = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // 22-flit packet: 20 DATA flits each flipping 5 bits, TAIL repeats last.
    task automatic walking_pkt(input int stall);
        logic [63:0] p = rnd64();
        logic [63:0] five = 64'h1F;
        step(1'b1, TY_HEAD, p, 2'd2);
        for (int k = 0; k < 20; k++) begin
            p = p ^ (five << ((k * 5) % 59));
            step(1'b1, TY_DATA, p, 2'd2);
            if (stall > 0) bubbles(stall);
        end
        step(1'b1, TY_TAIL, p, 2'd2);
        check_eq("walk_done", pkt_done, 1);
        check_eq("walk_len", pkt_len, 22);
        check_eq("walk_tog", pkt_toggles, 100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ones = '1;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_ = 1'b1;

        // Basic packet: 0,0,0,0 then all-ones TAIL.
        step(1'b1, TY_HEAD, 64'd0, 2'd1);
        repeat (3) step(1'b1, TY_DATA, 64'd0, 2'd1);
        step(1'b1, TY_TAIL, ones, 2'd1);
        check_eq("t1_done", pkt_done, 1);
        check_eq("t1_len", pkt_len, 5);
        check_eq("t1_tog", pkt_toggles, 64);
        check_eq("t1_cnt", pkt_cnt, 1);
        check_eq("t1_err", err, 0);
        bubbles(2);

        // Ten walking packets with idle gaps.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            walking_pkt(0);
            bubbles(7);
        end
        check_eq("walk_cnt", pkt_cnt, 10);

        // Same packet with 3-cycle stalls between DATA flits.
        walking_pkt(3);
        bubbles(3);

        // Orphan DATA, then a clean HEAD/TAIL.
        do_reset();
        step(1'b1, TY_DATA, rnd64(), 2'd0);
        check_eq("orphan_err", err, 1);
        check_eq("orphan_code", err_code, 1);
        check_eq("orphan_cnt", pkt_cnt, 0);
        step(1'b1, TY_HEAD, rnd64(), 2'd3);
        step(1'b1, TY_TAIL, rnd64(), 2'd3);
        check_eq("ht_len", pkt_len, 2);
        check_eq("ht_code", err_code, 1);

        // Nested HEAD, then mid-packet reset.
        do_reset();
        step(1'b1, TY_HEAD, rnd64(), 2'd1);
        step(1'b1, TY_DATA, rnd64(), 2'd1);
        step(1'b1, TY_HEAD, rnd64(), 2'd2);
        check_eq("nest_done", pkt_done, 0);
        step(1'b1, TY_DATA, rnd64(), 2'd2);
        step(1'b1, TY_TAIL, rnd64(), 2'd2);
        check_eq("nest_code", err_code, 2);
        check_eq("nest_len", pkt_len, 3);
        check_eq("nest_cnt", pkt_cnt, 1);
        step(1'b1, TY_HEAD, rnd64(), 2'd0);
        step(1'b1, TY_DATA, rnd64(), 2'd0);
        do_reset();
        check_eq("rst_cnt", pkt_cnt, 0);
        check_eq("rst_len", pkt_len, 0);

        // NONE type inside a body: error 3, packet continues.
        step(1'b1, TY_HEAD, rnd64(), 2'd1);
        step(1'b1, TY_NONE, rnd64(), 2'd1);
        check_eq("none_code", err_code, 3);
        step(1'b1, TY_TAIL, rnd64(), 2'd1);
        check_eq("none_len", pkt_len, 2);

        // VC mismatch inside a body (error only with the check enabled).
        do_reset();
        step(1'b1, TY_HEAD, rnd64(), 2'd1);
        step(1'b1, TY_DATA, rnd64(), 2'd2);
        step(1'b1, TY_TAIL, rnd64(), 2'd1);
        check_eq("vch_vch", pkt_vch, 1);
        check_eq("vch_len", pkt_len, 3);
`ifdef FLIT_SINK_VCH_CHECK_EN
        check_eq("vch_code", err_code, 4);
`else
        check_eq("vch_noerr", err, 0);
`endif

        // Long alternating packet saturates both length and toggles.
        do_reset();
        step(1'b1, TY_HEAD, 64'd0, 2'd3);
        for (int k = 1; k < 1100; k++) step(1'b1, TY_DATA, (k % 2) ? ones : 64'd0, 2'd3);
        step(1'b1, TY_TAIL, ones, 2'd3);
        check_eq("sat_len", pkt_len, 255);
        check_eq("sat_tog", pkt_toggles, 65535);

        // Random streams, reset between segments so each can hit a new first error.
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                int r = $urandom_range(0, 99);
                logic [1:0] ty;
                logic [VCHW-1:0] vc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : m_vch;
                if (!m_in_pkt) vc = 2'($urandom_range(0, 3));
                if (r < 15) begin
                    step(1'b0, 2'($urandom_range(0, 3)), rnd64(), vc);
                end else begin
                    if (r < 17) ty = TY_NONE;
                    else if (r < 20) ty = TY_HEAD;
                    else if (r < 85) ty = TY_DATA;
                    else ty = TY_TAIL;
                    if (!m_in_pkt && r >= 20 && r < 95) ty = TY_HEAD;
                    step(1'b1, ty, rnd64(), vc);
                end
            end
        end

        bubbles(2);
        check_eq("res_q_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flit_sink.md
Name: flit_sink

Overview:
- Receive-side endpoint for the router flit interface, attached to a mux/crossbar output port (odata/ovalid/ovch).
- Parses HEAD/DATA/TAIL flit framing, measures packet length, and accumulates payload bit-toggle counts between consecutive flits for energy characterization.
- Reports per-packet results and flags framing errors.
- Consumes the stream produced by the packet injection task. No backpressure.

Parameters:
- DATAW, 66, total flit width; type field is the top 2 bits, payload is the lower DATAW-2 bits.
- VCHW, 2, virtual-channel id width.
- LENW, 8, packet-length counter width; saturates.
- TOGW, 16, toggle accumulator width; saturates.
- CNTW, 16, received-packet counter width; wraps.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_, input, 1, asynchronous active-low reset.
- idata, input, DATAW, incoming flit.
- ivalid, input, 1, flit valid; sampled every clk.
- ivch, input, VCHW, virtual channel of the flit.
- pkt_done, output, 1, one-cycle pulse when a packet completes.
- pkt_len, output, LENW, flit count of the last packet, including HEAD and TAIL.
- pkt_vch, output, VCHW, VC latched from the HEAD of the last packet.
- pkt_toggles, output, TOGW, total payload bit toggles in the last packet.
- pkt_cnt, output, CNTW, number of completed packets.
- err, output, 1, sticky error flag.
- err_code, output, 3, code of the first error since reset.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_).
- Reset values: all outputs 0. FSM in IDLE. Internal prev-flit register and accumulators cleared.
- Type encoding (idata[DATAW-1:DATAW-2]): 2'b00 NONE, 2'b01 HEAD, 2'b10 TAIL, 2'b11 DATA.
- Only cycles with ivalid=1 are processed. ivalid=0 is a bubble: no state change in either state, and packets may stall mid-body indefinitely.
- IDLE + HEAD:
  - Latch vch and prev = payload.
  - len = 1, tog = 0.
  - Go to BODY.
- IDLE + DATA or TAIL: orphan flit, error code 1. Flit dropped, stay IDLE.
- BODY + DATA:
  - len += 1.
  - tog += popcount(payload XOR prev).
  - prev = payload.
- BODY + TAIL: same accumulation as DATA. Then register results into pkt_len/pkt_vch/pkt_toggles, pulse pkt_done, increment pkt_cnt, go to IDLE.
- BODY + HEAD: nested head, error code 2.
  - Current packet discarded; no pkt_done.
  - The new HEAD starts a fresh packet (len=1, tog=0, stay BODY).
- Any state + NONE with ivalid=1: bad type, error code 3. Flit ignored, state unchanged.
- Latency: pkt_done and updated result outputs are visible in the cycle after the TAIL is sampled. Results hold until the next completion.
- HEAD-only-then-TAIL gives len=2. A single-flit packet is not supported: HEAD followed by HEAD is error 2.
- Saturation:
  - len saturates at 2^LENW-1.
  - tog saturates at 2^TOGW-1.
  - pkt_cnt wraps modulo 2^CNTW.
- err/err_code: err sets on the first error. err_code holds the first error code; later errors do not overwrite it. Cleared only by reset.
- Reset mid-packet: everything returns to reset values immediately. A packet in progress is lost silently.
- Popcount is combinational over DATAW-2 bits, feeding a registered accumulator. No multi-cycle paths.

Optional Feature:
- Macro: FLIT_SINK_VCH_CHECK_EN.
- Defined: in BODY, any valid DATA/TAIL whose ivch differs from the latched HEAD vch raises error code 4. The flit is still accumulated; a TAIL still completes the packet.
- Undefined: ivch is sampled only on HEAD; code 4 is never produced.

Test Plan:
- Reset, then HEAD (payload 0), 3 DATA (payload 0), TAIL (payload all-ones 64'hFFFF_FFFF_FFFF_FFFF) -> one cycle after TAIL: pkt_done=1, pkt_len=5, pkt_toggles=64, pkt_cnt=1, err=0.
- Walking-ones sequence of 22 flits (HEAD, 20 DATA each differing by 5 bits from prior, TAIL equal to last DATA), with 7 idle cycles between packets, ×10 packets -> each pkt_len=22, pkt_toggles=100, pkt_cnt=10 at end.
- Same packet with ivalid deasserted for 3 cycles between DATA flits -> results identical to unstalled run; no pkt_done until TAIL+1.
- DATA flit in IDLE -> err=1, err_code=1, pkt_cnt unchanged. Then a clean HEAD/TAIL pair -> pkt_len=2, err_code still 1.
- HEAD, DATA, HEAD, DATA, TAIL -> err_code=2, single pkt_done with pkt_len=3. rst_ asserted mid-packet -> all outputs 0 asynchronously.
- With FLIT_SINK_VCH_CHECK_EN: HEAD on vch=1, DATA on vch=2, TAIL on vch=1 -> err_code=4, pkt_done with pkt_vch=1, pkt_len=3.
